mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side target for the core's memory handshake (mem_read/mem_write/mem_size/mem_addr_ready in, mem_data_ready out).
- Holds a word-organised RAM.
- Serves instruction fetches and loads with a programmable wait-state count; commits stores in a single cycle.
- Drives load data onto the shared bus when enabled.
- Sits between the control/datapath and the system bus; replaces the behavioural memory in the bench.

Parameters:
- DEPTH_WORDS, 131072, RAM size in 32-bit words (covers 0x00000-0x7FFFF).
- WAIT_STATES, 1, idle cycles between request acceptance and the response; range 0-15.
- INIT_FILE, "", hex image loaded by $readmemh at elaboration; empty means the RAM is left uninitialised.

Ports:
- clk  in  1  system clock; all state changes on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- addr  in  32  byte address from the address bus.
- wdata  in  32  store data; the shared bus value.
- mem_read  in  1  read request qualifier.
- mem_write  in  1  write strobe.
- mem_size  in  4  one-hot {signed byte, unsigned byte, signed half, unsigned half}; 0 means word.
- mem_addr_ready  in  1  registered address-valid from the initiator.
- mem_data_ready  out  1  read response valid; one-cycle pulse.
- rdata  out  32  formatted load data.
- rdata_oe  out  1  bus drive enable for rdata; high only with mem_data_ready.

Behaviour:
- Reset (async, reset_n=0): FSM=IDLE, wait counter=0, mem_data_ready=0, rdata_oe=0, rdata=0. RAM contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT when mem_read && mem_addr_ready && !mem_write. addr and mem_size are latched and the counter is loaded with WAIT_STATES.
  - If WAIT_STATES=0, IDLE goes directly to RESP.
  - WAIT: counter decrements each cycle; -> RESP when counter reaches 0.
  - RESP: mem_data_ready=1 and rdata_oe=1 for exactly one cycle; then -> IDLE.
- Read latency: WAIT_STATES+1 cycles from the accepting posedge to the posedge at which mem_data_ready is sampled high.
- Abort: if mem_read deasserts in WAIT (initiator trap), -> IDLE with no response. rdata_oe is never asserted in this case.
- Back-to-back reads: after RESP, a request is accepted only once mem_addr_ready is seen high again in IDLE. The initiator clears mem_addr_ready on the same edge it samples mem_data_ready, so no duplicate response occurs.
- Read formatting uses the latched addr[1:0] = o, read from word addr[31:2]:
  - word: the raw word.
  - signed byte: byte o, sign-extended. Unsigned byte: byte o, zero-extended.
  - signed half: bytes o..o+1, sign-extended, for o in {0,1,2}. Unsigned half: zero-extended.
  - o=3 on a halfword or misaligned words: the initiator traps these. The responder returns raw-word behaviour with no special handling.
- Writes are posted. At any posedge with mem_write=1, bytes are written at addr[31:2] without waiting for mem_addr_ready and without asserting mem_data_ready.
  - Byte: wdata[7:0] written to lane o.
  - Half: wdata[15:0] written to lanes o, o+1 (o in 0..2).
  - Word: all four lanes.
- mem_write and mem_read both high: the write is performed and the read is ignored.
- Out of range (addr[31:2] >= DEPTH_WORDS):
  - Reads complete normally with rdata=0.
  - Writes are dropped. The RAM is not aliased.
- rdata holds its last value when rdata_oe=0.
- Reset asserted mid-read clears FSM and outputs immediately; no partial response after release.

Test Plan:
- Fetch, WAIT_STATES=1: RAM[0]=0x00500093; mem_read=1, mem_addr_ready=1, addr=0 -> mem_data_ready and rdata_oe high exactly on cycle 2, rdata=0x00500093, low on cycle 3.
- Byte loads, RAM[4]=0x80FF7F01:
  - addr=0x13, signed byte -> 0xFFFFFF80.
  - addr=0x12, unsigned byte -> 0x000000FF.
  - addr=0x11, signed half -> 0xFFFFFF7F.
  - addr=0x12, unsigned half -> 0x000080FF.
- Stores:
  - word 0xDEADBEEF to 0x20, then byte 0x55 to 0x21, then half 0x1234 to 0x22; read word 0x20 -> 0x123455EF.
  - Each store takes one cycle with no mem_data_ready pulse.
- Abort: WAIT_STATES=3; read accepted, mem_read dropped after 1 cycle -> no mem_data_ready for 10 cycles. A new read to 0x0 then completes normally.
- Out of range: read 0x00080000 -> mem_data_ready after latency, rdata=0. A write 0xFFFFFFFF to 0x00080000 followed by a read of 0x0 shows RAM[0] unchanged.
- Reset mid-WAIT: reset_n low for 1 cycle during WAIT -> mem_data_ready and rdata_oe stay 0, FSM in IDLE. Previously written RAM data is still readable.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder: word RAM with posted stores and wait-stated loads.
// Load data is sign/zero formatted from the latched address offset.
module mem_responder #(
  parameter int DEPTH_WORDS = 131072,
  parameter int WAIT_STATES = 1,
  parameter     INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [3:0]  mem_size,
  input  logic        mem_addr_ready,
  output logic        mem_data_ready,
  output logic [31:0] rdata,
  output logic        rdata_oe
);

  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_e;

  logic [31:0] ram [DEPTH_WORDS];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  size_q, size_d;
  logic [31:0] rdata_q, rdata_d;

  logic        load_rdata;
  logic [31:0] rd_addr;
  logic [3:0]  rd_size;
  logic        rd_in_range;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] rd_fmt;

  logic        wr_in_range;
  logic [3:0]  wr_base;
  logic [3:0]  wr_mask;
  logic [31:0] wr_data;

  always_comb begin
    rd_addr = (state_q == S_IDLE) ? addr : addr_q;
    rd_size = (state_q == S_IDLE) ? mem_size : size_q;
    rd_in_range = ({2'b00, rd_addr[31:2]} < 32'(DEPTH_WORDS));
    rd_word = rd_in_range ? ram[rd_addr[AW+1:2]] : 32'h0;
    rd_shift = rd_word >> {rd_addr[1:0], 3'b000};
    rd_fmt = rd_word;
    unique case (1'b1)
      rd_size[3]: rd_fmt = {{24{rd_shift[7]}}, rd_shift[7:0]};
      rd_size[2]: rd_fmt = {24'h0, rd_shift[7:0]};
      rd_size[1]: begin
        if (rd_addr[1:0] != 2'd3)
          rd_fmt = {{16{rd_shift[15]}}, rd_shift[15:0]};
      end
      rd_size[0]: begin
        if (rd_addr[1:0] != 2'd3)
          rd_fmt = {16'h0, rd_shift[15:0]};
      end
      default: rd_fmt = rd_word;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    size_d     = size_q;
    load_rdata = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read && mem_addr_ready && !mem_write) begin
          addr_d = addr;
          size_d = mem_size;
          if (WAIT_STATES == 0) begin
            state_d    = S_RESP;
            load_rdata = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!mem_read) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          cnt_d      = 4'd0;
          load_rdata = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    rdata_d = load_rdata ? rd_fmt : rdata_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'h0;
      size_q  <= 4'h0;
      rdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    wr_in_range = ({2'b00, addr[31:2]} < 32'(DEPTH_WORDS));
    if (mem_size[3] || mem_size[2])
      wr_base = 4'b0001;
    else if (mem_size[1] || mem_size[0])
      wr_base = 4'b0011;
    else
      wr_base = 4'b1111;
    wr_mask = wr_base << addr[1:0];
    wr_data = wdata << {addr[1:0], 3'b000};
  end

  always_ff @(posedge clk) begin
    if (mem_write && wr_in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_mask[i])
          ram[addr[AW+1:2]][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign mem_data_ready = (state_q == S_RESP);
  assign rdata_oe       = (state_q == S_RESP);
  assign rdata          = rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a one-wait-state instance for most
// checks and a three-wait-state instance for abort and reset cases.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [3:0]  mem_size = '0;
    logic        mem_addr_ready = 1'b0;

    logic        rdy1, oe1, rdy3, oe3;
    logic [31:0] rd1, rd3;

    int tests = 0;
    int fails = 0;

    localparam logic [3:0] SZ_W  = 4'b0000;
    localparam logic [3:0] SZ_SB = 4'b1000;
    localparam logic [3:0] SZ_UB = 4'b0100;
    localparam logic [3:0] SZ_SH = 4'b0010;
    localparam logic [3:0] SZ_UH = 4'b0001;

    always #5 clk = ~clk;

    mem_responder #(.WAIT_STATES(1)) dut (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr_ready(mem_addr_ready), .mem_data_ready(rdy1),
        .rdata(rd1), .rdata_oe(oe1)
    );

    mem_responder #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .addr(addr), .wdata(wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_size(mem_size),
        .mem_addr_ready(mem_addr_ready), .mem_data_ready(rdy3),
        .rdata(rd3), .rdata_oe(oe3)
    );

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [3:0]  sz;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] sz, input bit with_read);
        @(negedge clk);
        addr = a;
        wdata = d;
        mem_size = sz;
        mem_write = 1'b1;
        mem_read = with_read;
        mem_addr_ready = with_read;
        @(posedge clk);
        #1;
        mem_write = 1'b0;
        mem_read = 1'b0;
        mem_addr_ready = 1'b0;
    endtask

    task automatic do_read(input string nm, input logic [31:0] a,
                           input logic [3:0] sz, input bit use3,
                           input logic [31:0] exp_d, input int exp_lat);
        int lat;
        logic [31:0] d;
        logic oe;
        lat = 0;
        d = '0;
        oe = 1'b0;
        @(negedge clk);
        addr = a;
        mem_size = sz;
        mem_read = 1'b1;
        mem_addr_ready = 1'b1;
        @(posedge clk);
        #1 mem_addr_ready = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if ((use3 ? rdy3 : rdy1) === 1'b1) begin
                lat = i;
                d = use3 ? rd3 : rd1;
                oe = use3 ? oe3 : oe1;
                break;
            end
            @(posedge clk);
        end
        chk({nm, " latency"}, 32'(lat), 32'(exp_lat));
        chk({nm, " rdata"}, d, exp_d);
        chk({nm, " rdata_oe"}, {31'h0, oe}, 32'h1);
        @(posedge clk);
        @(negedge clk);
        chk({nm, " pulse end"}, {31'h0, use3 ? rdy3 : rdy1}, 32'h0);
        mem_read = 1'b0;
    endtask

    initial begin
        int hits;
        vecs[0] = '{"fetch word", 32'h00, SZ_W, 32'h00500093};
        vecs[1] = '{"lb 0x13", 32'h13, SZ_SB, 32'hFFFFFF80};
        vecs[2] = '{"lbu 0x12", 32'h12, SZ_UB, 32'h000000FF};
        vecs[3] = '{"lh 0x11", 32'h11, SZ_SH, 32'hFFFFFF7F};
        vecs[4] = '{"lhu 0x12", 32'h12, SZ_UH, 32'h000080FF};
        vecs[5] = '{"lb 0x10", 32'h10, SZ_SB, 32'h00000001};
        vecs[6] = '{"lb 0x11", 32'h11, SZ_SB, 32'h0000007F};
        vecs[7] = '{"lh 0x10", 32'h10, SZ_SH, 32'h00007F01};
        vecs[8] = '{"lh 0x12", 32'h12, SZ_SH, 32'hFFFF80FF};
        vecs[9] = '{"lhu o3 raw", 32'h13, SZ_UH, 32'h80FF7F01};

        #12;
        chk("reset rdy", {31'h0, rdy1}, 32'h0);
        chk("reset oe", {31'h0, oe1}, 32'h0);
        chk("reset rdata", rd1, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        do_write(32'h00, 32'h00500093, SZ_W, 1'b0);
        do_write(32'h10, 32'h80FF7F01, SZ_W, 1'b0);
        repeat (4) @(posedge clk);

        foreach (vecs[i])
            do_read(vecs[i].name, vecs[i].a, vecs[i].sz, 1'b0,
                    vecs[i].exp, 2);

        hits = 0;
        do_write(32'h20, 32'hDEADBEEF, SZ_W, 1'b0);
        if (rdy1 || rdy3) hits++;
        do_write(32'h21, 32'hAAAAAA55, SZ_UB, 1'b0);
        if (rdy1 || rdy3) hits++;
        do_write(32'h22, 32'hBBBB1234, SZ_UH, 1'b0);
        if (rdy1 || rdy3) hits++;
        chk("store no pulse", 32'(hits), 32'h0);
        do_read("merged stores", 32'h20, SZ_W, 1'b0, 32'h123455EF, 2);

        hits = 0;
        do_write(32'h30, 32'h11111111, SZ_W, 1'b1);
        repeat (5) begin
            @(negedge clk);
            if (rdy1 || rdy3) hits++;
        end
        chk("rd+wr no resp", 32'(hits), 32'h0);
        do_read("rd+wr data", 32'h30, SZ_W, 1'b0, 32'h11111111, 2);

        do_read("oor read", 32'h00080000, SZ_W, 1'b0, 32'h0, 2);
        do_write(32'h00080000, 32'hFFFFFFFF, SZ_W, 1'b0);
        do_read("oor no alias", 32'h00, SZ_W, 1'b0, 32'h00500093, 2);

        repeat (6) @(posedge clk);
        @(negedge clk);
        addr = 32'h10;
        mem_size = SZ_W;
        mem_read = 1'b1;
        mem_addr_ready = 1'b1;
        @(posedge clk);
        #1 mem_addr_ready = 1'b0;
        @(negedge clk);
        mem_read = 1'b0;
        hits = 0;
        repeat (10) begin
            @(negedge clk);
            if (rdy3 || oe3) hits++;
        end
        chk("abort no resp", 32'(hits), 32'h0);
        do_read("after abort", 32'h00, SZ_W, 1'b1, 32'h00500093, 4);

        repeat (6) @(posedge clk);
        @(negedge clk);
        addr = 32'h10;
        mem_size = SZ_W;
        mem_read = 1'b1;
        mem_addr_ready = 1'b1;
        @(posedge clk);
        #1 mem_addr_ready = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("reset mid-wait rdy", {31'h0, rdy3}, 32'h0);
        chk("reset mid-wait rdata", rd3, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        hits = 0;
        repeat (8) begin
            @(negedge clk);
            if (rdy3 || oe3 || rdy1 || oe1) hits++;
        end
        chk("no resp after reset", 32'(hits), 32'h0);
        mem_read = 1'b0;
        do_read("ram kept", 32'h20, SZ_W, 1'b1, 32'h123455EF, 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
